// File: rtl/mu_pool_spike_counter_if.sv
// rtl/mu_pool_spike_counter_if.sv - spike stream and weight-write bus for the motor-unit pool counter
interface mu_pool_spike_counter_if #(
    parameter int IDX_W  = 3,
    parameter int GAIN_W = 16
);
    logic              spike_valid;
    logic              spike;
    logic [IDX_W-1:0]  spike_idx;
    logic              gain_we;
    logic [IDX_W-1:0]  gain_addr;
    logic [GAIN_W-1:0] gain_data;

    modport master (
        output spike_valid, spike, spike_idx,
        output gain_we, gain_addr, gain_data
    );

    modport slave (
        input spike_valid, spike, spike_idx,
        input gain_we, gain_addr, gain_data
    );
endinterface

// File: rtl/mu_pool_spike_counter.sv
// rtl/mu_pool_spike_counter.sv - per-unit spike counters with windowed snapshot and serial pooled drive sum
module mu_pool_spike_counter #(
    parameter int NUM_MU = 8,
    parameter int IDX_W  = 3,
    parameter int CNT_W  = 16,
    parameter int GAIN_W = 16,
    parameter int SUM_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset_sim_n,
    mu_pool_spike_counter_if.slave     mu_if,
    input  logic                       sim_tick,
    input  logic                       mode,
    input  logic [IDX_W-1:0]           rd_addr,
    output logic [CNT_W-1:0]           rd_data,
    output logic [SUM_W-1:0]           cnt_out,
    output logic                       cnt_valid,
    output logic                       busy,
    output logic                       sat,
    output logic                       overrun
);
    localparam int PROD_W = CNT_W + GAIN_W;
    // One spare bit above the wider of product/accumulator so the add never wraps before clamping.
    localparam int EXT_W  = ((PROD_W > SUM_W) ? PROD_W : SUM_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [EXT_W-1:0] SUM_MAX_EXT = {{(EXT_W-SUM_W){1'b0}}, {SUM_W{1'b1}}};
    localparam logic [IDX_W:0]   NUM_MU_EXT  = (IDX_W+1)'(NUM_MU);
    localparam logic [IDX_W-1:0] LAST_CH     = IDX_W'(NUM_MU - 1);

    typedef enum logic [1:0] {S_IDLE, S_SUM, S_DONE} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  live [NUM_MU];
    logic [CNT_W-1:0]  snap [NUM_MU];
    logic [GAIN_W-1:0] gain [NUM_MU];
    logic              sat_live;
    logic              sat_acc;
    logic              mode_r;
    logic [IDX_W-1:0]  ch;
    logic [SUM_W-1:0]  acc;

    logic              tick_acc;
    logic              spike_ok;
    logic              gain_ok;
    logic              rd_ok;
    logic [NUM_MU-1:0] hit;
    logic [GAIN_W-1:0] mult;
    logic [EXT_W-1:0]  prod_ext;
    logic [EXT_W-1:0]  sum_ext;
    logic              clamp;
    logic [SUM_W-1:0]  acc_step;

    assign tick_acc = sim_tick && (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign spike_ok = mu_if.spike_valid && mu_if.spike && ({1'b0, mu_if.spike_idx} < NUM_MU_EXT);
    assign gain_ok  = mu_if.gain_we && ({1'b0, mu_if.gain_addr} < NUM_MU_EXT);
    assign rd_ok    = ({1'b0, rd_addr} < NUM_MU_EXT);

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_MU; i++) begin
            hit[i] = spike_ok && (mu_if.spike_idx == IDX_W'(i));
        end
    end

    // Saturating multiply-accumulate for the channel currently being summed.
    always_comb begin
        mult     = mode_r ? gain[ch] : GAIN_W'(1);
        prod_ext = EXT_W'(snap[ch]) * EXT_W'(mult);
        sum_ext  = EXT_W'(acc) + prod_ext;
        clamp    = (sum_ext > SUM_MAX_EXT);
        acc_step = clamp ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
    end

    // A spike coinciding with an accepted tick belongs to the new window.
    always_ff @(posedge clk or negedge reset_sim_n) begin
        if (!reset_sim_n) begin
            for (int i = 0; i < NUM_MU; i++) begin
                live[i] <= '0;
                snap[i] <= '0;
            end
            sat_live <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_MU; i++) begin
                if (tick_acc) begin
                    snap[i] <= live[i];
                    live[i] <= hit[i] ? CNT_W'(1) : '0;
                end else if (hit[i]) begin
                    if (live[i] == CNT_MAX) begin
                        sat_live <= 1'b1;
                    end else begin
                        live[i] <= live[i] + CNT_W'(1);
                    end
                end
            end
            if (tick_acc) begin
                sat_live <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_sim_n) begin
        if (!reset_sim_n) begin
            for (int i = 0; i < NUM_MU; i++) begin
                gain[i] <= GAIN_W'(1);
            end
        end else if (gain_ok) begin
            gain[mu_if.gain_addr] <= mu_if.gain_data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (tick_acc) state_nxt = S_SUM;
            S_SUM:   if (ch == LAST_CH) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_sim_n) begin
        if (!reset_sim_n) begin
            state     <= S_IDLE;
            ch        <= '0;
            acc       <= '0;
            mode_r    <= 1'b0;
            sat_acc   <= 1'b0;
            cnt_out   <= '0;
            cnt_valid <= 1'b0;
            sat       <= 1'b0;
            overrun   <= 1'b0;
            rd_data   <= '0;
        end else begin
            state     <= state_nxt;
            cnt_valid <= 1'b0;
            overrun   <= sim_tick && (state != S_IDLE);
            rd_data   <= rd_ok ? snap[rd_addr] : '0;
            case (state)
                S_IDLE: begin
                    if (tick_acc) begin
                        acc     <= '0;
                        ch      <= '0;
                        mode_r  <= mode;
                        sat_acc <= sat_live;
                    end
                end
                S_SUM: begin
                    acc <= acc_step;
                    ch  <= ch + IDX_W'(1);
                    if (clamp) begin
                        sat_acc <= 1'b1;
                    end
                    // Result is presented during the DONE cycle.
                    if (ch == LAST_CH) begin
                        cnt_out   <= acc_step;
                        sat       <= sat_acc | clamp;
                        cnt_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mu_pool_spike_counter.sv
// tb/tb_mu_pool_spike_counter.sv - directed vector bench for mu_pool_spike_counter
module tb_mu_pool_spike_counter;
    logic        clk;
    logic        rst_n;

    logic        sim_tick;
    logic        mode;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [31:0] cnt_out;
    logic        cnt_valid;
    logic        busy;
    logic        sat;
    logic        overrun;

    logic        s2_tick;
    logic        s2_mode;
    logic [2:0]  s2_rd_addr;
    logic [3:0]  s2_rd_data;
    logic [15:0] s2_cnt_out;
    logic        s2_cnt_valid;
    logic        s2_busy;
    logic        s2_sat;
    logic        s2_overrun;

    mu_pool_spike_counter_if #(.IDX_W(3), .GAIN_W(16)) bus ();
    mu_pool_spike_counter_if #(.IDX_W(3), .GAIN_W(16)) bus2 ();

    mu_pool_spike_counter #(
        .NUM_MU(8), .IDX_W(3), .CNT_W(16), .GAIN_W(16), .SUM_W(32)
    ) dut (
        .clk(clk), .reset_sim_n(rst_n), .mu_if(bus), .sim_tick(sim_tick), .mode(mode),
        .rd_addr(rd_addr), .rd_data(rd_data), .cnt_out(cnt_out), .cnt_valid(cnt_valid),
        .busy(busy), .sat(sat), .overrun(overrun)
    );

    mu_pool_spike_counter #(
        .NUM_MU(8), .IDX_W(3), .CNT_W(4), .GAIN_W(16), .SUM_W(16)
    ) dut_sat (
        .clk(clk), .reset_sim_n(rst_n), .mu_if(bus2), .sim_tick(s2_tick), .mode(s2_mode),
        .rd_addr(s2_rd_addr), .rd_data(s2_rd_data), .cnt_out(s2_cnt_out), .cnt_valid(s2_cnt_valid),
        .busy(s2_busy), .sat(s2_sat), .overrun(s2_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             mode;
        logic [7:0][7:0]  spk;
        logic [7:0][15:0] gn;
        logic [31:0]      exp_out;
        logic             exp_sat;
    } vec_t;

    vec_t vecs [5];
    int   n_vec = 0;
    int   n_bad = 0;
    int   valid_cnt = 0;
    int   overrun_cnt = 0;
    logic [31:0] last_out = '0;

    always @(negedge clk) begin
        if (cnt_valid === 1'b1) begin
            valid_cnt <= valid_cnt + 1;
            last_out  <= cnt_out;
        end
        if (overrun === 1'b1) overrun_cnt <= overrun_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic spike1(input int u);
        bus.spike_valid = 1'b1; bus.spike = 1'b1; bus.spike_idx = 3'(u);
        step();
        bus.spike = 1'b0;
        step();
        bus.spike_valid = 1'b0; bus.spike = 1'b1;
        step();
        bus.spike = 1'b0;
    endtask

    task automatic write_gain(input int a, input logic [15:0] d);
        bus.gain_we = 1'b1; bus.gain_addr = 3'(a); bus.gain_data = d;
        step();
        bus.gain_we = 1'b0;
    endtask

    task automatic read_snap(input int a, input logic [15:0] exp, input string name);
        rd_addr = 3'(a);
        step();
        check(name, 64'(rd_data), 64'(exp));
    endtask

    task automatic tick_wait(input int sp_u, input logic [31:0] exp_out, input logic exp_sat,
                             input string name);
        int lat;
        lat = -1;
        sim_tick = 1'b1;
        if (sp_u >= 0) begin
            bus.spike_valid = 1'b1; bus.spike = 1'b1; bus.spike_idx = 3'(sp_u);
        end
        step();
        sim_tick = 1'b0; bus.spike_valid = 1'b0; bus.spike = 1'b0;
        check({name, " busy"}, 64'(busy), 64'd1);
        for (int n = 1; n <= 30; n++) begin
            if (cnt_valid === 1'b1) begin
                lat = n;
                break;
            end
            step();
        end
        check({name, " latency"}, 64'(lat), 64'd9);
        check({name, " cnt_out"}, 64'(cnt_out), 64'(exp_out));
        check({name, " sat"}, 64'(sat), 64'(exp_sat));
        step();
        check({name, " idle"}, {62'd0, busy, cnt_valid}, 64'd0);
    endtask

    task automatic spike2(input int u, input int n);
        for (int k = 0; k < n; k++) begin
            bus2.spike_valid = 1'b1; bus2.spike = 1'b1; bus2.spike_idx = 3'(u);
            step();
        end
        bus2.spike_valid = 1'b0; bus2.spike = 1'b0;
    endtask

    task automatic tick2(input logic [15:0] exp_out, input logic exp_sat, input string name);
        int lat;
        lat = -1;
        s2_tick = 1'b1;
        step();
        s2_tick = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (s2_cnt_valid === 1'b1) begin
                lat = n;
                break;
            end
            step();
        end
        check({name, " found"}, 64'(lat), 64'd9);
        check({name, " cnt_out"}, 64'(s2_cnt_out), 64'(exp_out));
        check({name, " sat"}, 64'(s2_sat), 64'(exp_sat));
        step();
    endtask

    initial begin
        int v0;
        int o0;
        vecs[0] = '{1'b0, {8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3}, {8{16'd1}}, 32'd8, 1'b0};
        vecs[1] = '{1'b1, {8{8'd2}},
                    {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 32'd72, 1'b0};
        vecs[2] = '{1'b0, {8{8'd1}},
                    {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 32'd8, 1'b0};
        vecs[3] = '{1'b1, {8'd3, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0},
                    {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 32'd28, 1'b0};
        vecs[4] = '{1'b1, {8'd0, 8'd0, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd9},
                    {16'd0, 16'd0, 16'd1000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 32'd4000, 1'b0};

        rst_n = 1'b0;
        sim_tick = 1'b0; mode = 1'b0; rd_addr = '0;
        bus.spike_valid = 1'b0; bus.spike = 1'b0; bus.spike_idx = '0;
        bus.gain_we = 1'b0; bus.gain_addr = '0; bus.gain_data = '0;
        s2_tick = 1'b0; s2_mode = 1'b0; s2_rd_addr = '0;
        bus2.spike_valid = 1'b0; bus2.spike = 1'b0; bus2.spike_idx = '0;
        bus2.gain_we = 1'b0; bus2.gain_addr = '0; bus2.gain_data = '0;
        step(3);
        check("reset cnt_out", 64'(cnt_out), 64'd0);
        check("reset flags", {59'd0, cnt_valid, busy, sat, overrun, 1'b0}, 64'd0);
        check("reset rd_data", 64'(rd_data), 64'd0);
        check("reset sat inst", {59'd0, s2_cnt_valid, s2_busy, s2_sat, s2_overrun, 1'b0}, 64'd0);
        rst_n = 1'b1;
        step(2);

        for (int v = 0; v < 5; v++) begin
            for (int u = 0; u < 8; u++) write_gain(u, vecs[v].gn[u]);
            mode = vecs[v].mode;
            for (int u = 0; u < 8; u++)
                for (int k = 0; k < int'(vecs[v].spk[u]); k++) spike1(u);
            tick_wait(-1, vecs[v].exp_out, vecs[v].exp_sat, $sformatf("vec%0d", v));
            for (int u = 0; u < 8; u++)
                read_snap(u, 16'(vecs[v].spk[u]), $sformatf("vec%0d rd%0d", v, u));
        end

        // Spike coinciding with the tick lands in the next window
        mode = 1'b0;
        spike1(1); spike1(1);
        tick_wait(2, 32'd2, 1'b0, "coinc win1");
        read_snap(2, 16'd0, "coinc rd2 old");
        tick_wait(-1, 32'd1, 1'b0, "coinc win2");
        read_snap(2, 16'd1, "coinc rd2 new");

        // Tick while busy: overrun, no extra result, counts carry over
        spike1(4);
        v0 = valid_cnt; o0 = overrun_cnt;
        sim_tick = 1'b1; step(); sim_tick = 1'b0;
        step(2);
        sim_tick = 1'b1; step(); sim_tick = 1'b0;
        check("overrun pulse", 64'(overrun), 64'd1);
        step();
        check("overrun one cycle", 64'(overrun), 64'd0);
        spike1(4); spike1(4);
        step(15);
        check("overrun results", 64'(valid_cnt - v0), 64'd1);
        check("overrun pulses", 64'(overrun_cnt - o0), 64'd1);
        check("overrun first out", 64'(last_out), 64'd1);
        tick_wait(-1, 32'd2, 1'b0, "overrun carry");

        // Reset in the middle of SUM
        write_gain(0, 16'd5);
        mode = 1'b1;
        spike1(0); spike1(0); spike1(0);
        sim_tick = 1'b1; step(); sim_tick = 1'b0;
        step(2);
        v0 = valid_cnt;
        rst_n = 1'b0;
        step();
        check("midrst cnt_out", 64'(cnt_out), 64'd0);
        check("midrst flags", {59'd0, cnt_valid, busy, sat, overrun, 1'b0}, 64'd0);
        check("midrst rd_data", 64'(rd_data), 64'd0);
        step(2);
        rst_n = 1'b1;
        step(12);
        check("midrst no result", 64'(valid_cnt - v0), 64'd0);
        mode = 1'b1;
        spike1(0); spike1(0); spike1(0); spike1(0);
        tick_wait(-1, 32'd4, 1'b0, "post reset");

        // Narrow instance: counter and accumulator saturation
        s2_mode = 1'b0;
        spike2(1, 20);
        tick2(16'd15, 1'b1, "sat cnt");
        s2_rd_addr = 3'd1; step();
        check("sat rd1", 64'(s2_rd_data), 64'd15);
        bus2.gain_we = 1'b1; bus2.gain_addr = 3'd1; bus2.gain_data = 16'hFFFF;
        step();
        bus2.gain_we = 1'b0;
        s2_mode = 1'b1;
        spike2(1, 20);
        tick2(16'hFFFF, 1'b1, "sat acc");
        spike2(1, 1);
        tick2(16'hFFFF, 1'b0, "sat edge");
        s2_mode = 1'b0;
        spike2(1, 2);
        tick2(16'd2, 1'b0, "sat clear");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
